// File: rtl/mux_arb_n_if.sv
// Bundle of the channel-side and output-side handshake signals of mux_arb_n.
// The master modport drives the inputs; the slave modport is the arbiter itself.
interface mux_arb_n_if #(
   parameter int WIDTH = 64,
   parameter int N     = 8,
   parameter int SELW  = $clog2(N)
);
   logic [N*WIDTH-1:0] in_data;
   logic [N-1:0]       in_valid;
   logic [N-1:0]       in_ready;
   logic               mode;
   logic [SELW-1:0]    sel;
   logic [WIDTH-1:0]   out_data;
   logic [SELW-1:0]    out_src;
   logic               out_valid;
   logic               out_ready;

   modport master (
      output in_data, in_valid, mode, sel, out_ready,
      input  in_ready, out_data, out_src, out_valid
   );

   modport slave (
      input  in_data, in_valid, mode, sel, out_ready,
      output in_ready, out_data, out_src, out_valid
   );
endinterface

// File: rtl/mux_arb_n.sv
// N-input arbitrating multiplexer: fixed-select or round-robin grant feeding a
// single registered, valid/ready output stage.
module mux_arb_n #(
   parameter int WIDTH = 64,
   parameter int N     = 8,
   parameter int SELW  = $clog2(N)
) (
   input logic        clk,
   input logic        reset,
   mux_arb_n_if.slave bus
);
   localparam int              PADN = 1 << SELW;
   localparam logic [SELW:0]   N_L  = (SELW+1)'(N);
   localparam logic [SELW-1:0] LAST = SELW'(N - 1);

   logic [WIDTH-1:0] chan_data [N];
   logic [PADN-1:0]  valid_pad;
   logic [N-1:0]     in_ready_w;
   logic [SELW-1:0]  grant;
   logic             grant_valid;
   logic             load;
   logic             xfer;
   int               scan_idx;

   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic [SELW-1:0]  out_src_q,  out_src_d;
   logic             out_valid_q, out_valid_d;
   logic [SELW-1:0]  ptr_q,      ptr_d;

   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_chan
         assign chan_data[gi]  = bus.in_data[gi*WIDTH +: WIDTH];
         assign in_ready_w[gi] = xfer && (grant == SELW'(gi));
      end
   endgenerate

   // Padding lets an out-of-range sel index the valid vector safely.
   assign valid_pad = PADN'(bus.in_valid);

   always_comb begin
      grant_valid = 1'b0;
      grant       = '0;
      scan_idx    = 0;
      if (!bus.mode) begin
         if (({1'b0, bus.sel} < N_L) && valid_pad[bus.sel]) begin
            grant_valid = 1'b1;
            grant       = bus.sel;
         end
      end else begin
         for (int k = 0; k < N; k++) begin
            scan_idx = int'(ptr_q) + k;
            if (scan_idx >= N) scan_idx = scan_idx - N;
            if (!grant_valid && bus.in_valid[scan_idx]) begin
               grant_valid = 1'b1;
               grant       = SELW'(scan_idx);
            end
         end
      end
   end

   // Reset gates the handshake so no channel sees a transfer while it is held.
   assign load = !out_valid_q || bus.out_ready;
   assign xfer = load && grant_valid && !reset;

   always_comb begin
      out_data_d  = out_data_q;
      out_src_d   = out_src_q;
      out_valid_d = out_valid_q;
      ptr_d       = ptr_q;
      if (xfer) begin
         out_data_d  = chan_data[grant];
         out_src_d   = grant;
         out_valid_d = 1'b1;
         if (bus.mode) ptr_d = (grant == LAST) ? '0 : grant + SELW'(1);
      end else if (out_valid_q && bus.out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_data_q  <= '0;
         out_src_q   <= '0;
         out_valid_q <= 1'b0;
         ptr_q       <= '0;
      end else begin
         out_data_q  <= out_data_d;
         out_src_q   <= out_src_d;
         out_valid_q <= out_valid_d;
         ptr_q       <= ptr_d;
      end
   end

   assign bus.in_ready  = in_ready_w;
   assign bus.out_data  = out_data_q;
   assign bus.out_src   = out_src_q;
   assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_mux_arb_n.sv
// Directed bench for mux_arb_n: an 8-channel/64-bit instance and a
// 5-channel/16-bit instance, with hand-computed expectations.
module tb_mux_arb_n;
   logic clk;
   logic rst8;
   logic rst5;
   int   tests;
   int   failures;

   mux_arb_n_if #(.WIDTH(64), .N(8)) b8 ();
   mux_arb_n_if #(.WIDTH(16), .N(5)) b5 ();

   mux_arb_n #(.WIDTH(64), .N(8)) u8 (.clk(clk), .reset(rst8), .bus(b8));
   mux_arb_n #(.WIDTH(16), .N(5)) u5 (.clk(clk), .reset(rst5), .bus(b5));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [63:0] chan8(input int i);
      logic [63:0] base;
      base = 64'h1111_0000_0000_0000;
      return base * 64'(i) + 64'(i);
   endfunction

   function automatic logic [15:0] chan5(input int i);
      return 16'h1000 * 16'(i + 1) + 16'(i);
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [7:0] one8;
      logic [4:0] one5;
      int         e;
      int         seq_a [4];
      tests    = 0;
      failures = 0;
      one8     = 8'h01;
      one5     = 5'h01;
      seq_a    = '{2, 7, 2, 7};

      for (int i = 0; i < 8; i++) b8.in_data[i*64 +: 64] = chan8(i);
      for (int i = 0; i < 5; i++) b5.in_data[i*16 +: 16] = chan5(i);
      rst8 = 1'b1;  rst5 = 1'b1;
      b8.in_valid = 8'hFF; b8.mode = 1'b1; b8.sel = 3'd0; b8.out_ready = 1'b1;
      b5.in_valid = 5'h1F; b5.mode = 1'b1; b5.sel = 3'd0; b5.out_ready = 1'b1;

      // Reset held for two cycles with every channel valid.
      #1;
      chk("rst_ready_pre", 64'(b8.in_ready), 64'h0);
      for (int c = 0; c < 2; c++) begin
         tick();
         chk("rst_valid", 64'(b8.out_valid), 64'h0);
         chk("rst_data",  b8.out_data,       64'h0);
         chk("rst_src",   64'(b8.out_src),   64'h0);
         chk("rst_ready", 64'(b8.in_ready),  64'h0);
         $display("[TB] reset cycle %0d out_valid=%0b", c, b8.out_valid);
      end
      rst8 = 1'b0;
      #1;
      chk("rr_first_ready", 64'(b8.in_ready), 64'h01);
      tick();
      chk("rr_first_src",  64'(b8.out_src), 64'h0);
      chk("rr_first_data", b8.out_data,     chan8(0));
      $display("[TB] first rr grant src=%0d", b8.out_src);

      // Fixed-mode sweep over every channel.
      b8.mode = 1'b0;
      for (int s = 0; s < 8; s++) begin
         b8.sel = 3'(s);
         #1;
         chk("fix_ready", 64'(b8.in_ready), 64'(one8 << s));
         tick();
         chk("fix_src",   64'(b8.out_src),   64'(s));
         chk("fix_data",  b8.out_data,       chan8(s));
         chk("fix_valid", 64'(b8.out_valid), 64'h1);
         $display("[TB] fixed sel=%0d src=%0d data=%h", s, b8.out_src, b8.out_data);
      end

      // Fixed mode pointing at an invalid channel: drain, no refill.
      b8.sel = 3'd5;
      b8.in_valid = 8'b1101_1111;
      #1;
      chk("inv_ready", 64'(b8.in_ready), 64'h0);
      tick();
      chk("inv_valid", 64'(b8.out_valid), 64'h0);
      chk("inv_src",   64'(b8.out_src),   64'h7);
      chk("inv_data",  b8.out_data,       chan8(7));
      tick();
      chk("inv_valid2", 64'(b8.out_valid), 64'h0);
      chk("inv_ready2", 64'(b8.in_ready),  64'h0);
      $display("[TB] fixed invalid sel=5 out_valid=%0b", b8.out_valid);

      // A lone grant on channel 7 wraps the pointer back to 0.
      b8.mode = 1'b1;
      b8.in_valid = 8'h80;
      tick();
      chk("wrap8_src", 64'(b8.out_src), 64'h7);

      // Round-robin rotation with all channels valid.
      b8.in_valid = 8'hFF;
      for (int k = 0; k < 16; k++) begin
         e = k % 8;
         #1;
         chk("rr_ready", 64'(b8.in_ready), 64'(one8 << e));
         tick();
         chk("rr_src",  64'(b8.out_src), 64'(e));
         chk("rr_data", b8.out_data,     chan8(e));
         $display("[TB] rr beat %0d src=%0d", k, b8.out_src);
      end

      // Sparse valid set alternates between channels 2 and 7.
      b8.in_valid = 8'b1000_0100;
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("rr_sparse_src", 64'(b8.out_src), 64'(seq_a[k]));
         $display("[TB] rr sparse beat %0d src=%0d", k, b8.out_src);
      end

      // Backpressure on a beat from channel 3; mode/sel wiggle meanwhile.
      b8.in_valid = 8'h08;
      tick();
      chk("bp_load_src", 64'(b8.out_src), 64'h3);
      b8.out_ready = 1'b0;
      b8.in_valid  = 8'hFF;
      for (int c = 0; c < 5; c++) begin
         b8.mode = c[0];
         b8.sel  = 3'(c + 1);
         #1;
         chk("bp_ready", 64'(b8.in_ready), 64'h0);
         tick();
         chk("bp_valid", 64'(b8.out_valid), 64'h1);
         chk("bp_src",   64'(b8.out_src),   64'h3);
         chk("bp_data",  b8.out_data,       chan8(3));
         $display("[TB] stall cycle %0d src=%0d", c, b8.out_src);
      end
      b8.mode = 1'b1;
      b8.out_ready = 1'b1;
      #1;
      chk("bp_release_ready", 64'(b8.in_ready), 64'h10);
      tick();
      chk("bp_release_valid", 64'(b8.out_valid), 64'h1);
      chk("bp_release_src",   64'(b8.out_src),   64'h4);
      chk("bp_release_data",  b8.out_data,       chan8(4));
      $display("[TB] release drain+refill src=%0d", b8.out_src);

      // N=5: round-robin wrap 4 -> 0.
      rst5 = 1'b0;
      for (int k = 0; k < 7; k++) begin
         e = k % 5;
         #1;
         chk("n5_ready", 64'(b5.in_ready), 64'(one5 << e));
         tick();
         chk("n5_src",  64'(b5.out_src), 64'(e));
         chk("n5_data", 64'(b5.out_data), 64'(chan5(e)));
         $display("[TB] n5 rr beat %0d src=%0d", k, b5.out_src);
      end

      // N=5: out-of-range sel gives no grant.
      b5.mode = 1'b0;
      b5.sel  = 3'd6;
      #1;
      chk("n5_sel6_ready", 64'(b5.in_ready), 64'h0);
      tick();
      chk("n5_sel6_valid", 64'(b5.out_valid), 64'h0);
      b5.sel = 3'd4;
      tick();
      chk("n5_sel4_src",   64'(b5.out_src),   64'h4);
      chk("n5_sel4_valid", 64'(b5.out_valid), 64'h1);
      $display("[TB] n5 fixed sel=4 src=%0d", b5.out_src);

      // N=5: reset while a beat is held; pointer returns to 0.
      rst5 = 1'b1;
      b5.out_ready = 1'b0;
      b5.mode = 1'b1;
      #1;
      chk("n5_rst_ready", 64'(b5.in_ready), 64'h0);
      tick();
      chk("n5_rst_valid", 64'(b5.out_valid), 64'h0);
      chk("n5_rst_src",   64'(b5.out_src),   64'h0);
      chk("n5_rst_data",  64'(b5.out_data),  64'h0);
      rst5 = 1'b0;
      b5.out_ready = 1'b1;
      #1;
      chk("n5_post_rst_ready", 64'(b5.in_ready), 64'h01);
      tick();
      chk("n5_post_rst_src", 64'(b5.out_src), 64'h0);
      $display("[TB] n5 post-reset grant src=%0d", b5.out_src);

      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end
endmodule

// File: doc/mux_arb_n.md
# mux_arb_n

Parametrised N-input, WIDTH-bit arbitrating multiplexer with a registered, handshaked output stage. It generalises the ALU's fixed 8:1 single-bit select mux into a sequential block. In fixed mode it forwards one software-selected channel. In round-robin mode it arbitrates fairly among all valid channels. Intended uses are result/forwarding-source selection and shared-port arbitration between pipeline stages.

## Interface
Parameters:
- WIDTH, 64, data bits per channel.
- N, 8, number of input channels (N >= 2; N need not be a power of two).
- SELW, $clog2(N), width of select/source fields (derived; do not override).

Ports:
- clk  input  1  single clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- in_data  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  N  per-channel valid.
- in_ready  output  N  per-channel ready; transfer on channel i when in_valid[i] & in_ready[i].
- mode  input  1  0 = fixed select, 1 = round-robin.
- sel  input  SELW  channel index used in fixed mode.
- out_data  output  WIDTH  registered selected data.
- out_src  output  SELW  index of the channel that produced out_data.
- out_valid  output  1  output register holds a beat.
- out_ready  input  1  downstream accepts; transfer when out_valid & out_ready.

## Operation
- State: one output register {out_data, out_src, out_valid} and a round-robin pointer ptr[SELW].
- load = !out_valid | out_ready. The register may accept a new beat when empty or when being drained in the same cycle.
- Grant (combinational):
  - Fixed mode: grant = sel if sel < N and in_valid[sel]. Otherwise no grant.
  - Round-robin mode: grant = first i with in_valid[i], scanning ptr, ptr+1, …, N-1, 0, …, ptr-1. No grant if no channel is valid.
- in_ready[i] = load & grant_valid & (grant == i). At most one bit of in_ready is high. in_ready is 0 on every non-granted channel, including valid ones.
- On a transfer: out_data <= in_data[grant], out_src <= grant, out_valid <= 1.
  - In round-robin mode only, ptr <= (grant == N-1) ? 0 : grant+1.
- Drain without refill (out_valid & out_ready & no grant): out_valid <= 0. out_data and out_src hold their last values.
- Stall (out_valid & !out_ready): out_data, out_src and out_valid hold. in_ready is all-zero.
- ptr holds in fixed mode and when no grant occurs. A mode switch takes effect on the next grant and does not reset ptr.
- sel and mode are sampled only in cycles where load is high. Changes during a stall have no effect on the held beat.
- No combinational path from in_data to out_data. There is a combinational path from out_ready, in_valid, mode and sel to in_ready.

## Timing
- Reset (synchronous, asserted at posedge): out_valid=0, out_data=0, out_src=0, ptr=0. in_ready is all-zero while reset is high.
- Reset mid-operation discards any held beat. The first grant after reset scans from channel 0.
- Latency: input transfer in cycle t, data visible on out_data in cycle t+1.
- Throughput: 1 beat/cycle sustained when out_ready stays high.
- Simultaneous drain and refill in one cycle: out_valid stays 1 and the new beat replaces the old one. There are no bubbles.
- Round-robin fairness: with all N channels continuously valid, each channel is granted exactly once per N consecutive grants.
- Wrap-around: a grant on channel N-1 sets ptr to 0. For non-power-of-two N, ptr never takes a value >= N.

## Test plan
- Reset, then check outputs. With N=8 and WIDTH=64, drive reset for 2 cycles with all inputs valid → out_valid=0, out_data=0, out_src=0 and in_ready=0 throughout. The first post-reset round-robin grant goes to channel 0.
- Fixed-mode sweep. Set mode=0, in_data[i]=64'h1111_0000_0000_0000*i+i, all valid, out_ready=1, and step sel from 0 to 7 one cycle each → out_src follows sel with 1-cycle latency, out_data matches each channel, and only in_ready[sel] is high.
- Fixed mode, invalid channel. Set sel=5 with in_valid=8'b1101_1111 → no transfer and in_ready=0. out_valid drops to 0 after the current beat drains.
- Round-robin rotation. Set mode=1, in_valid=8'hFF, out_ready=1 for 16 cycles → out_src sequence is 0,1,…,7,0,…,7. Then with in_valid=8'b1000_0100 starting at ptr=0 → grants alternate 2,7,2,7.
- Backpressure. Hold out_ready=0 for 5 cycles with a beat from channel 3 held → out_data, out_src=3 and out_valid are stable, and in_ready=0. When out_ready is released, a drain and refill occur in the same cycle with no bubble.
- Non-power-of-two N and mid-operation reset. With N=5 and all valid in round-robin, the sequence 4→0 wraps correctly. In fixed mode, sel=6 gives no grant. Asserting reset while out_valid=1 gives out_valid=0 on the next cycle and ptr=0.
